// File: rtl/acc_seq_ctrl_if.sv
// Shared req/ack memory port of the accumulator sequencer.
// Instruction fetch and operand load/store both travel over this port.
interface acc_seq_ctrl_if #(
    parameter int AW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   rdata;
    logic          ack;

    modport master (output req, output we, output addr, input rdata, input ack);
    modport slave  (input req, input we, input addr, output rdata, output ack);
endinterface

// File: rtl/acc_seq_ctrl.sv
// Multi-cycle control sequencer for the 32-bit accumulator datapath.
// Owns PC, IR and MDR and runs the FETCH/DECODE/MEM/EXEC/HALT machine.
module acc_seq_ctrl #(
    parameter int AW = 16
) (
    input  logic           clk,
    input  logic           rst,
    acc_seq_ctrl_if.master mem,
    input  logic           acc_zero,
    output logic           ldac,
    output logic           asel,
    output logic [31:0]    a_data,
    output logic [2:0]     alu_op,
    output logic [AW-1:0]  pc,
    output logic           halted,
    output logic           illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic          ldac;
        logic          asel;
        logic [2:0]    alu_op;
        logic [31:0]   a_data;
        logic          halted;
        logic          illegal;
    } outs_t;

    function automatic logic is_alu(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STA) || is_alu(op);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {[4'hB:4'hE]};
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        code = 3'b000;
        case (op)
            OP_SUB:  code = 3'b001;
            OP_AND:  code = 3'b010;
            OP_OR:   code = 3'b011;
            OP_XOR:  code = 3'b100;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // NOP and illegal opcodes both fall through to FETCH.
    function automatic state_t decode_next(input logic [3:0] op);
        state_t nxt;
        nxt = S_FETCH;
        if (is_mem(op))
            nxt = S_MEM;
        else if (op == OP_LDI)
            nxt = S_EXEC;
        else if (op == OP_HLT)
            nxt = S_HALT;
        return nxt;
    endfunction

    // Output image of a state; evaluated for the state being entered so the
    // outputs come straight from flops yet stay a pure function of state/ir.
    function automatic outs_t state_outs(input state_t s, input logic [31:0] ir_v,
                                         input logic [31:0] mdr_v, input logic [AW-1:0] pc_v);
        outs_t o;
        logic [3:0] op;
        op = ir_v[31:28];
        o = '0;
        o.a_data = (op == OP_LDI) ? {4'b0000, ir_v[27:0]} : mdr_v;
        case (s)
            S_FETCH: begin
                o.req  = 1'b1;
                o.addr = pc_v;
            end
            S_DECODE: o.illegal = is_illegal(op);
            S_MEM: begin
                o.req  = 1'b1;
                o.we   = (op == OP_STA);
                o.addr = ir_v[AW-1:0];
            end
            S_EXEC: begin
                o.ldac   = 1'b1;
                o.asel   = is_alu(op);
                o.alu_op = alu_code(op);
            end
            S_HALT:  o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [31:0]   ir;
    logic [31:0]   mdr;
    outs_t         outs;

    logic [3:0]    opc;
    logic [AW-1:0] ir_addr;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_dec;
    logic          take;
    state_t        dec_state;

    assign opc       = ir[31:28];
    assign ir_addr   = ir[AW-1:0];
    assign pc_inc    = pc_q + PC_ONE;
    assign dec_state = decode_next(opc);
    assign pc_dec    = ((opc == OP_JMP) || ((opc == OP_JZ) && acc_zero)) ? ir_addr : pc_q;
    // An ack only counts against our own registered request, so a stale ack
    // left over from before reset is never taken.
    assign take      = outs.req & mem.ack;

    // NOTE: state and outputs share one always_ff with non-blocking updates, so
    // every register samples pre-edge values and no ordering hazard exists.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            pc_q  <= '0;
            ir    <= '0;
            mdr   <= '0;
            outs  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (take) begin
                        ir    <= mem.rdata;
                        pc_q  <= pc_inc;
                        state <= S_DECODE;
                        outs  <= state_outs(S_DECODE, mem.rdata, mdr, pc_inc);
                    end else begin
                        outs  <= state_outs(S_FETCH, ir, mdr, pc_q);
                    end
                end
                S_DECODE: begin
                    pc_q  <= pc_dec;
                    state <= dec_state;
                    outs  <= state_outs(dec_state, ir, mdr, pc_dec);
                end
                S_MEM: begin
                    if (take) begin
                        if (opc == OP_STA) begin
                            state <= S_FETCH;
                            outs  <= state_outs(S_FETCH, ir, mdr, pc_q);
                        end else begin
                            mdr   <= mem.rdata;
                            state <= S_EXEC;
                            outs  <= state_outs(S_EXEC, ir, mem.rdata, pc_q);
                        end
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    outs  <= state_outs(S_FETCH, ir, mdr, pc_q);
                end
                S_HALT: begin
                    outs  <= state_outs(S_HALT, ir, mdr, pc_q);
                end
                default: begin
                    state <= S_FETCH;
                    outs  <= state_outs(S_FETCH, ir, mdr, pc_q);
                end
            endcase
        end
    end

    assign mem.req  = outs.req;
    assign mem.we   = outs.we;
    assign mem.addr = outs.addr;
    assign ldac     = outs.ldac;
    assign asel     = outs.asel;
    assign alu_op   = outs.alu_op;
    assign a_data   = outs.a_data;
    assign halted   = outs.halted;
    assign illegal  = outs.illegal;
    assign pc       = pc_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: accumulator/ALU datapath, random-wait memory and an
// instruction-level model that predicts every access, acc value and latency.
`timescale 1ns/1ps
module tb_acc_seq_ctrl;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          acc_zero;
    logic          ldac;
    logic          asel;
    logic [31:0]   a_data;
    logic [2:0]    alu_op;
    logic [AW-1:0] pc;
    logic          halted;
    logic          illegal;

    acc_seq_ctrl_if #(.AW(AW)) mem_bus ();

    acc_seq_ctrl #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem      (mem_bus),
        .acc_zero (acc_zero),
        .ldac     (ldac),
        .asel     (asel),
        .a_data   (a_data),
        .alu_op   (alu_op),
        .pc       (pc),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Accumulator + ALU datapath driven by the sequencer's strobes.
    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'b000:  return x + y;
            3'b001:  return x - y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            3'b100:  return x ^ y;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    logic [31:0] acc;
    always @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (ldac)
            acc <= asel ? alu(alu_op, acc, a_data) : a_data;
    end
    assign acc_zero = (acc == 32'd0);

    // Instruction-set semantics of the memory-operand opcodes.
    function automatic logic [31:0] isa_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        case (op)
            4'h1:    return d;
            4'h3:    return a + d;
            4'h4:    return a - d;
            4'h5:    return a & d;
            4'h6:    return a | d;
            4'h7:    return a ^ d;
            default: return a;
        endcase
    endfunction

    logic [31:0]   mem_img [0:65535];
    int            wait_max      = 0;
    int            force_wr_wait = -1;
    bit            spurious_en   = 0;

    int            cyc = 0;
    int            waits_left, cur_waits, ack_waits, wr_hold;
    bit            ack_live, new_access, prev_req, prev_we, prev_ill;
    logic [AW-1:0] prev_addr, ack_addr;
    bit            ack_we;

    logic [AW-1:0] m_pc, m_opaddr, m_pn;
    logic [31:0]   m_acc, m_w;
    logic [3:0]    m_op;
    bit            m_expect_op, m_opwe, m_halt, m_first;
    int            m_prev_base, m_prev_opwaits, last_fetch_cyc;
    int            fetch_cnt, m_ldac_cnt, m_ill_cnt, dut_ldac_cnt, dut_ill_cnt;

    // Memory slave and reference model, stepped once per cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mem_bus.ack = 1'b0;
            mem_bus.rdata = '0;
            ack_live = 0; new_access = 1; prev_req = 0; prev_ill = 0; wr_hold = 0;
            m_pc = '0; m_acc = '0; m_expect_op = 0; m_halt = 0; m_first = 1;
            m_prev_base = 0; m_prev_opwaits = 0; fetch_cnt = 0;
            m_ldac_cnt = 0; m_ill_cnt = 0; dut_ldac_cnt = 0; dut_ill_cnt = 0;
        end else begin
            if (!ldac)
                check("idle_ctl", {28'd0, asel, alu_op}, 32'd0);
            else
                dut_ldac_cnt++;
            if (illegal) begin
                dut_ill_cnt++;
                check("ill_width", {31'd0, prev_ill}, 32'd0);
            end
            prev_ill = illegal;

            if (prev_req && !ack_live) begin
                check("hold_req",  {31'd0, mem_bus.req}, 32'd1);
                check("hold_addr", mem_bus.addr, prev_addr);
                check("hold_we",   {31'd0, mem_bus.we}, {31'd0, prev_we});
            end

            if (ack_live) begin
                if (m_halt) begin
                    check("access_after_halt", 32'd1, 32'd0);
                end else if (!m_expect_op) begin
                    check("fetch_addr", ack_addr, m_pc);
                    check("fetch_we", {31'd0, ack_we}, 32'd0);
                    check("acc", acc, m_acc);
                    m_pn = m_pc + 1'b1;
                    check("pc_inc", pc, m_pn);
                    if (!m_first)
                        check("latency", 32'(cyc - last_fetch_cyc),
                              32'(m_prev_base + m_prev_opwaits + ack_waits));
                    m_first = 0;
                    last_fetch_cyc = cyc;
                    m_prev_opwaits = 0;
                    fetch_cnt++;
                    m_w  = mem_img[m_pc];
                    m_op = m_w[31:28];
                    m_pc = m_pn;
                    case (m_op)
                        4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            m_expect_op = 1; m_opwe = 0; m_opaddr = m_w[AW-1:0];
                            m_prev_base = 4; m_ldac_cnt++;
                        end
                        4'h2: begin
                            m_expect_op = 1; m_opwe = 1; m_opaddr = m_w[AW-1:0];
                            m_prev_base = 3;
                        end
                        4'h8: begin
                            m_acc = {4'b0000, m_w[27:0]}; m_prev_base = 3; m_ldac_cnt++;
                        end
                        4'h9: begin
                            m_pc = m_w[AW-1:0]; m_prev_base = 2;
                        end
                        4'hA: begin
                            if (m_acc == 32'd0) m_pc = m_w[AW-1:0];
                            m_prev_base = 2;
                        end
                        4'hF: m_halt = 1;
                        4'hB, 4'hC, 4'hD, 4'hE: begin
                            m_ill_cnt++; m_prev_base = 2;
                        end
                        default: m_prev_base = 2;
                    endcase
                end else begin
                    check("op_addr", ack_addr, m_opaddr);
                    check("op_we", {31'd0, ack_we}, {31'd0, m_opwe});
                    if (m_opwe) begin
                        check("sta_data", acc, m_acc);
                        check("we_drop", {31'd0, mem_bus.we}, 32'd0);
                        if (force_wr_wait >= 0)
                            check("sta_hold", 32'(wr_hold), 32'(force_wr_wait + 1));
                    end else begin
                        m_acc = isa_op(m_op, m_acc, mem_img[ack_addr]);
                    end
                    m_prev_opwaits = ack_waits;
                    m_expect_op = 0;
                end
                if (ack_we) mem_img[ack_addr] = acc;
                wr_hold = 0;
                new_access = 1;
            end

            prev_req  = mem_bus.req;
            prev_addr = mem_bus.addr;
            prev_we   = mem_bus.we;
            ack_live  = 0;
            if (mem_bus.req) begin
                if (new_access) begin
                    waits_left = (mem_bus.we && force_wr_wait >= 0) ? force_wr_wait
                                                                   : int'($urandom_range(0, wait_max));
                    cur_waits  = 0;
                    new_access = 0;
                end
                if (mem_bus.we) wr_hold++;
                if (waits_left == 0) begin
                    mem_bus.ack   = 1'b1;
                    mem_bus.rdata = mem_img[mem_bus.addr];
                    ack_live  = 1;
                    ack_addr  = mem_bus.addr;
                    ack_we    = mem_bus.we;
                    ack_waits = cur_waits;
                end else begin
                    mem_bus.ack   = 1'b0;
                    mem_bus.rdata = $urandom;
                    waits_left--;
                    cur_waits++;
                end
            end else begin
                mem_bus.ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_bus.rdata = $urandom;
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [3:0]  op;
        op = 4'($urandom_range(0, 14));
        w  = $urandom;
        w[31:28] = op;
        if (op inside {[4'h1:4'h7]})
            w[15:0] = 16'h0200 + 16'($urandom_range(0, 15));
        else if (op == 4'h9 || op == 4'hA)
            w[15:0] = 16'($urandom_range(0, 127));
        return w;
    endfunction

    task automatic load_directed();
        foreach (mem_img[i]) mem_img[i] = '0;
        mem_img[16'h0000] = 32'h9000_0010;  // JMP 0x10
        mem_img[16'h0010] = 32'h0000_0000;  // NOP
        mem_img[16'h0011] = 32'h8000_0005;  // LDI 5
        mem_img[16'h0012] = 32'h1000_0080;  // LDA 0x80
        mem_img[16'h0013] = 32'h3000_0080;  // ADD 0x80
        mem_img[16'h0014] = 32'h4000_0081;  // SUB 0x81
        mem_img[16'h0015] = 32'hA000_0040;  // JZ 0x40 (taken)
        mem_img[16'h0040] = 32'h8000_0001;  // LDI 1
        mem_img[16'h0041] = 32'hA000_0000;  // JZ 0 (not taken)
        mem_img[16'h0042] = 32'h2000_0020;  // STA 0x20
        mem_img[16'h0043] = 32'hB000_0000;  // illegal
        mem_img[16'h0044] = 32'h5000_0082;  // AND
        mem_img[16'h0045] = 32'h6000_0083;  // OR
        mem_img[16'h0046] = 32'h7000_0084;  // XOR
        mem_img[16'h0047] = 32'h1000_0085;  // LDA HLT word
        mem_img[16'h0048] = 32'h2000_0000;  // STA 0 -> HLT at address 0
        mem_img[16'h0049] = 32'h9000_FFFF;  // JMP 0xFFFF
        mem_img[16'hFFFF] = 32'h0000_0000;  // NOP, wraps to 0
        mem_img[16'h0080] = 32'd7;
        mem_img[16'h0081] = 32'd14;
        mem_img[16'h0082] = 32'hFFFF_FFF3;
        mem_img[16'h0083] = 32'h0000_0F00;
        mem_img[16'h0084] = 32'hFFFF_FFFF;
        mem_img[16'h0085] = 32'hF000_0000;
    endtask

    task automatic load_random();
        foreach (mem_img[i]) mem_img[i] = '0;
        for (int i = 0; i < 128; i++) mem_img[i] = rand_instr();
        mem_img[128] = 32'h9000_0000;
        for (int i = 0; i < 16; i++) mem_img[16'h0200 + i] = $urandom;
    endtask

    task automatic run_fetches(input int target, input int budget);
        int n;
        n = 0;
        while (fetch_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_progress", (fetch_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic reset_and_check();
        int n;
        n = 0;
        while (!mem_bus.req && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b0;
        #1;
        check("rst_req", {31'd0, mem_bus.req}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_ldac", {31'd0, ldac}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;
        load_directed();
        repeat (3) @(negedge clk);
        check("reset_req",     {31'd0, mem_bus.req}, 32'd0);
        check("reset_we",      {31'd0, mem_bus.we}, 32'd0);
        check("reset_pc",      pc, 32'd0);
        check("reset_ctl",     {26'd0, ldac, asel, alu_op, illegal}, 32'd0);
        check("reset_halted",  {31'd0, halted}, 32'd0);
        check("reset_a_data",  a_data, 32'd0);

        // Directed program, zero-wait memory, stores held for 3 wait cycles.
        force_wr_wait = 3;
        #2 rst = 1'b1;
        @(negedge clk);
        check("first_req",  {31'd0, mem_bus.req}, 32'd1);
        check("first_addr", mem_bus.addr, 32'd0);
        begin
            int n;
            n = 0;
            while (!halted && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, 32'd1);
        check("final_acc", acc, 32'hF000_0000);
        check("sta_mem20", mem_img[16'h0020], 32'd1);
        check("ldac_count", 32'(dut_ldac_cnt), 32'(m_ldac_cnt));
        check("ldac_count_abs", 32'(dut_ldac_cnt), 32'd9);
        check("illegal_count", 32'(dut_ill_cnt), 32'(m_ill_cnt));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_level", {30'd0, halted, mem_bus.req}, 32'd2);
            check("halt_ldac",  {31'd0, ldac}, 32'd0);
        end
        reset_and_check();

        // Random programs with random wait states and acks outside requests.
        force_wr_wait = -1;
        wait_max      = 3;
        spurious_en   = 1;
        for (int run = 0; run < 2; run++) begin
            load_random();
            #2 rst = 1'b1;
            run_fetches(250, 250 * 14);
            reset_and_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
